// File: rtl/input_conditioner_if.sv
// Pad-side bundle for input_conditioner: raw active-low inputs and controls in,
// conditioned levels, edge pulses and sticky flags out.
interface input_conditioner_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] nRaw;
  logic [CHANNELS-1:0] DebounceEn;
  logic [CHANNELS-1:0] Clear;
  logic [CHANNELS-1:0] Level;
  logic [CHANNELS-1:0] Press;
  logic [CHANNELS-1:0] Release;
  logic [CHANNELS-1:0] Event;
  logic [CHANNELS-1:0] Missed;

  modport master (
    output nRaw, DebounceEn, Clear,
    input  Level, Press, Release, Event, Missed
  );

  modport slave (
    input  nRaw, DebounceEn, Clear,
    output Level, Press, Release, Event, Missed
  );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel synchroniser, optional debounce filter, edge detector and sticky
// Event/Missed flags for asynchronous active-low pad inputs.
module input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic                 Clock,
  input logic                 nReset,
  input_conditioner_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] chain    [CHANNELS];
  logic [CNT_WIDTH-1:0]   cnt      [CHANNELS];
  logic [CNT_WIDTH-1:0]   cntNext  [CHANNELS];
  logic [CHANNELS-1:0]    syncLevel;
  logic [CHANNELS-1:0]    levelQ, levelNext;
  logic [CHANNELS-1:0]    pressQ, releaseQ;
  logic [CHANNELS-1:0]    eventQ, eventNext;
  logic [CHANNELS-1:0]    missedQ, missedNext;

  // Chains reset to 1 (inactive) so inputs already low at reset release
  // travel the normal path and produce exactly one Press.
  // NOTE: every register here, including the per-channel arrays, is reset
  // explicitly; these are a handful of flops, not a RAM, so that is cheap.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < CHANNELS; i++) chain[i] <= '1;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        chain[i] <= {chain[i][SYNC_STAGES-2:0], bus.nRaw[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) syncLevel[i] = ~chain[i][SYNC_STAGES-1];
  end

  // The count runs only while the synchronised input disagrees with Level;
  // reaching the last count accepts the new level instead of incrementing,
  // so the counter can never wrap.
  // NOTE: defaults are assigned before any branch so no path can infer a latch.
  always_comb begin
    levelNext = levelQ;
    for (int i = 0; i < CHANNELS; i++) begin
      cntNext[i] = '0;
      if (!bus.DebounceEn[i]) begin
        levelNext[i] = syncLevel[i];
      end else if (syncLevel[i] != levelQ[i]) begin
        if (cnt[i] >= CNT_LAST) levelNext[i] = syncLevel[i];
        else                    cntNext[i]   = cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Set wins over Clear for Event; Clear wins over set for Missed.
  always_comb begin
    eventNext  = pressQ | (eventQ & ~bus.Clear);
    missedNext = ~bus.Clear & (missedQ | (pressQ & eventQ));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      levelQ   <= '0;
      pressQ   <= '0;
      releaseQ <= '0;
      eventQ   <= '0;
      missedQ  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= cntNext[i];
      levelQ   <= levelNext;
      pressQ   <= levelNext & ~levelQ;
      releaseQ <= ~levelNext & levelQ;
      eventQ   <= eventNext;
      missedQ  <= missedNext;
    end
  end

  assign bus.Level   = levelQ;
  assign bus.Press   = pressQ;
  assign bus.Release = releaseQ;
  assign bus.Event   = eventQ;
  assign bus.Missed  = missedQ;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed test-plan scenarios plus randomized traffic for input_conditioner,
// compared every cycle against a window-based behavioural model.
module tb_input_conditioner;
  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 16;

  logic Clock = 1'b0;
  logic nReset;
  always #5 Clock = ~Clock;

  input_conditioner_if #(.CHANNELS(CH)) bus ();

  input_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .Clock (Clock),
    .nReset(nReset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [CH-1:0] mLevel, mPress, mRelease, mEvent, mMissed;
  logic [CH-1:0] rawQ[$];   // raw samples still in flight through the synchroniser
  logic [CH-1:0] diffQ[$];  // per edge: filter enabled and input disagreeing with Level

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mLevel = '0; mPress = '0; mRelease = '0; mEvent = '0; mMissed = '0;
    rawQ.delete();
    for (int k = 0; k < SYNC; k++) rawQ.push_back('1);
    diffQ.delete();
  endtask

  // A filtered channel accepts a new level once the input has disagreed with
  // Level on DEB consecutive enabled edges; acceptance consumes that evidence.
  task automatic modelEdge();
    logic [CH-1:0] s, newLvl, oldest, tmp;
    bit allDiff;
    oldest = rawQ.pop_front();
    rawQ.push_back(bus.nRaw);
    s = ~oldest;
    diffQ.push_back(bus.DebounceEn & (s ^ mLevel));
    if (diffQ.size() > DEB) void'(diffQ.pop_front());
    newLvl = mLevel;
    for (int i = 0; i < CH; i++) begin
      if (!bus.DebounceEn[i]) begin
        newLvl[i] = s[i];
      end else if (diffQ.size() == DEB) begin
        allDiff = 1'b1;
        for (int k = 0; k < DEB; k++) allDiff &= diffQ[k][i];
        if (allDiff) begin
          newLvl[i] = s[i];
          for (int k = 0; k < DEB; k++) begin
            tmp = diffQ[k]; tmp[i] = 1'b0; diffQ[k] = tmp;
          end
        end
      end
    end
    mMissed  = ~bus.Clear & (mMissed | (mPress & mEvent));
    mEvent   = mPress | (mEvent & ~bus.Clear);
    mPress   = newLvl & ~mLevel;
    mRelease = ~newLvl & mLevel;
    mLevel   = newLvl;
  endtask

  task automatic compareAll();
    check("level",   32'(bus.Level),   32'(mLevel));
    check("press",   32'(bus.Press),   32'(mPress));
    check("release", 32'(bus.Release), 32'(mRelease));
    check("event",   32'(bus.Event),   32'(mEvent));
    check("missed",  32'(bus.Missed),  32'(mMissed));
    check("press_and_release", 32'(bus.Press & bus.Release), 32'd0);
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge Clock);
    modelEdge();
    @(negedge Clock);
    compareAll();
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_level"},   32'(bus.Level),   32'd0);
    check({tag, "_press"},   32'(bus.Press),   32'd0);
    check({tag, "_release"}, 32'(bus.Release), 32'd0);
    check({tag, "_event"},   32'(bus.Event),   32'd0);
    check({tag, "_missed"},  32'(bus.Missed),  32'd0);
  endtask

  int hold [CH];
  int pressCnt, relCnt, firstEdge;
  bit found;
  logic [CH-1:0] tmpRaw, tmpEn;

  initial begin
    nReset         = 1'b0;
    bus.nRaw       = '1;
    bus.DebounceEn = '1;
    bus.Clear      = '0;
    modelReset();
    repeat (2) @(negedge Clock);
    checkAllZero("reset");
    nReset = 1'b1;
    tick();

    // Clean press on channel 0: first sampling edge is edge 1
    bus.nRaw[0] = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (e == 17) check("p0_level_e17", 32'(bus.Level[0]), 32'd0);
      if (e == 18) begin
        check("p0_level_e18", 32'(bus.Level[0]), 32'd1);
        check("p0_press_e18", 32'(bus.Press),    32'b0001);
      end
      if (e == 19) begin
        check("p0_press_e19", 32'(bus.Press), 32'd0);
        check("p0_event_e19", 32'(bus.Event), 32'b0001);
      end
    end
    check("p0_others_quiet", 32'(bus.Level[3:1]), 32'd0);

    // Glitch of 10 cycles on channel 1
    bus.nRaw[1] = 1'b0;
    repeat (10) tick();
    bus.nRaw[1] = 1'b1;
    repeat (20) tick();
    check("glitch_level", 32'(bus.Level[1]), 32'd0);
    check("glitch_event", 32'(bus.Event[1]), 32'd0);
    check("glitch_cnt",   32'(dut.cnt[1]),   32'd0);

    // Bypass on channel 2: three low cycles
    bus.DebounceEn[2] = 1'b0;
    tick();
    bus.nRaw[2] = 1'b0;
    pressCnt = 0; relCnt = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) bus.nRaw[2] = 1'b1;
      pressCnt += int'(bus.Press[2]);
      relCnt   += int'(bus.Release[2]);
      if (e == 2) check("bypass_level_e2", 32'(bus.Level[2]), 32'd0);
      if (e == 3) check("bypass_level_e3", 32'(bus.Level[2]), 32'd1);
      if (e == 5) check("bypass_level_e5", 32'(bus.Level[2]), 32'd1);
      if (e == 6) check("bypass_level_e6", 32'(bus.Level[2]), 32'd0);
    end
    check("bypass_presses",  32'(pressCnt), 32'd1);
    check("bypass_releases", 32'(relCnt),   32'd1);
    bus.DebounceEn[2] = 1'b1;
    tick();

    // Two accepted presses on channel 3 without Clear
    bus.nRaw[3] = 1'b0; repeat (20) tick();
    bus.nRaw[3] = 1'b1; repeat (20) tick();
    bus.nRaw[3] = 1'b0; repeat (20) tick();
    check("sticky_event",  32'(bus.Event[3]),  32'd1);
    check("sticky_missed", 32'(bus.Missed[3]), 32'd1);
    bus.Clear[3] = 1'b1; tick(); bus.Clear[3] = 1'b0;
    check("clear_event",  32'(bus.Event[3]),  32'd0);
    check("clear_missed", 32'(bus.Missed[3]), 32'd0);

    // Press on channel 0 coinciding with Clear while Event is already set
    bus.nRaw[0] = 1'b1; repeat (20) tick();
    bus.nRaw[0] = 1'b0;
    found = 1'b0;
    for (int e = 0; e < 40 && !found; e++) begin
      tick();
      found = bus.Press[0];
    end
    check("coinc_press_seen", 32'(found), 32'd1);
    bus.Clear[0] = 1'b1; tick(); bus.Clear[0] = 1'b0;
    check("coinc_event",  32'(bus.Event[0]),  32'd1);
    check("coinc_missed", 32'(bus.Missed[0]), 32'd0);

    // Reset in the middle of a count on channel 0
    bus.nRaw[0] = 1'b1; repeat (20) tick();
    bus.nRaw[0] = 1'b0; repeat (8) tick();
    #2 nReset = 1'b0;
    #1 checkAllZero("midreset");
    modelReset();
    @(posedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    firstEdge = 0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (bus.Level[0] && firstEdge == 0) firstEdge = e;
    end
    check("midreset_latency", 32'(firstEdge), 32'd18);

    // Randomized traffic: per-channel hold times, enable flips, clears
    for (int i = 0; i < CH; i++) hold[i] = int'($urandom_range(1, 40));
    for (int n = 0; n < 2500; n++) begin
      tmpRaw = bus.nRaw;
      tmpEn  = bus.DebounceEn;
      for (int i = 0; i < CH; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          tmpRaw[i] = ~tmpRaw[i];
          hold[i]   = int'($urandom_range(1, 40));
        end
        if ($urandom_range(0, 63) == 0) tmpEn[i] = ~tmpEn[i];
      end
      bus.nRaw       = tmpRaw;
      bus.DebounceEn = tmpEn;
      bus.Clear      = CH'($urandom_range(0, 7) == 0 ? $urandom : 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
